// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-wide, byte-addressed little-endian DMEM.
// Sub-word stores are done as read-modify-write. Optional macro: LSU_RANGE_CHECK_EN.
module dmem_lsu #(
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int REG_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_funct3,
    input  logic [REG_WIDTH-1:0]       req_addr,
    input  logic [REG_WIDTH-1:0]       req_wdata,
    output logic                       rsp_valid,
    output logic [REG_WIDTH-1:0]       rsp_rdata,
    output logic [1:0]                 rsp_err,
    output logic                       dmem_wr_en,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0]       dmem_wr_data,
    input  logic [REG_WIDTH-1:0]       dmem_data_out
);
    // Handshake: a request is taken when req_valid & req_ready at a rising edge;
    // rsp_valid is a single-cycle pulse with no backpressure.
    typedef enum logic [1:0] {IDLE, RD, MRG, WR} state_e;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;
    localparam logic [1:0] ERR_RANGE = 2'b11;

    state_e                       state_q, state_d;
    logic                         we_q, we_d;
    logic [2:0]                   funct3_q, funct3_d;
    logic [1:0]                   lane_q, lane_d;
    logic [REG_WIDTH-1:0]         wdata_q, wdata_d;
    logic                         err_pend_q, err_pend_d;
    logic [1:0]                   err_code_q, err_code_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [REG_WIDTH-1:0]         rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                   rsp_err_q, rsp_err_d;
    logic                         wr_en_q, wr_en_d;
    logic [DMEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [REG_WIDTH-1:0]         wr_data_q, wr_data_d;

    logic       f3_illegal, misaligned, out_of_range;
    logic [1:0] req_err;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [REG_WIDTH-1:0] load_val, merge_val;

    assign f3_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_RANGE_CHECK_EN
    assign out_of_range = |req_addr[REG_WIDTH-1:DMEM_ADDR_WIDTH];
`else
    // Upper address bits are dropped so accesses wrap modulo the DMEM size.
    logic unused_upper_addr;
    assign unused_upper_addr = ^req_addr[REG_WIDTH-1:DMEM_ADDR_WIDTH];
    assign out_of_range      = 1'b0;
`endif
    assign req_err = f3_illegal   ? ERR_F3 :
                     misaligned   ? ERR_ALIGN :
                     out_of_range ? ERR_RANGE : ERR_OK;

    always_comb begin
        sel_byte = dmem_data_out[7:0];
        case (lane_q)
            2'd0: sel_byte = dmem_data_out[7:0];
            2'd1: sel_byte = dmem_data_out[15:8];
            2'd2: sel_byte = dmem_data_out[23:16];
            2'd3: sel_byte = dmem_data_out[31:24];
            default: sel_byte = dmem_data_out[7:0];
        endcase
        sel_half = lane_q[1] ? dmem_data_out[31:16] : dmem_data_out[15:0];
        case (funct3_q)
            3'b000:  load_val = {{(REG_WIDTH-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{(REG_WIDTH-16){sel_half[15]}}, sel_half};
            3'b100:  load_val = {{(REG_WIDTH-8){1'b0}}, sel_byte};
            3'b101:  load_val = {{(REG_WIDTH-16){1'b0}}, sel_half};
            default: load_val = dmem_data_out;
        endcase
        merge_val = dmem_data_out;
        if (funct3_q[1:0] == 2'b00) begin
            case (lane_q)
                2'd0: merge_val[7:0]   = wdata_q[7:0];
                2'd1: merge_val[15:8]  = wdata_q[7:0];
                2'd2: merge_val[23:16] = wdata_q[7:0];
                2'd3: merge_val[31:24] = wdata_q[7:0];
                default: merge_val = dmem_data_out;
            endcase
        end else if (lane_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0] = wdata_q[15:0];
        end
    end

    // An error response is still owed while err_pend_q is set, so hold off new requests.
    assign req_ready = (state_q == IDLE) && !err_pend_q;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        err_pend_d  = 1'b0;
        err_code_d  = err_code_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = ERR_OK;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        if (err_pend_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_code_q;
        end
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    lane_d   = req_addr[1:0];
                    wdata_d  = req_wdata;
                    if (req_err != ERR_OK) begin
                        err_pend_d = 1'b1;
                        err_code_d = req_err;
                    end else begin
                        addr_d = {req_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
                        if (req_we && (req_funct3 == 3'b010)) begin
                            wr_data_d = req_wdata;
                            wr_en_d   = 1'b1;
                            state_d   = WR;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: state_d = MRG;
            MRG: begin
                if (we_q) begin
                    wr_data_d = merge_val;
                    wr_en_d   = 1'b1;
                    state_d   = WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_val;
                    state_d     = IDLE;
                end
            end
            WR: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            err_pend_q  <= 1'b0;
            err_code_q  <= ERR_OK;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            err_pend_q  <= err_pend_d;
            err_code_q  <= err_code_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign dmem_wr_en   = wr_en_q;
    assign dmem_addr    = addr_q;
    assign dmem_wr_data = wr_data_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a registered-read DMEM model.
// Follows LSU_RANGE_CHECK_EN for the out-of-range expectation.
module tb_dmem_lsu;
    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        dmem_wr_en;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wr_data;
    logic [31:0] dmem_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_lsu #(.DMEM_ADDR_WIDTH(10), .REG_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dmem_wr_en(dmem_wr_en), .dmem_addr(dmem_addr),
        .dmem_wr_data(dmem_wr_data), .dmem_data_out(dmem_data_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM model: write at the edge, registered read returning pre-write contents
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (dmem_wr_en) mem[dmem_addr[9:2]] <= dmem_wr_data;
        rd_q <= mem[dmem_addr[9:2]];
    end
    assign dmem_data_out = rd_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request; observes the 7 samples after the acceptance edge (k=0 is right after it)
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_err, input int exp_wr);
        int lat;
        int nv;
        int nw;
        logic [31:0] rd;
        logic [1:0]  er;
        lat = -1; nv = 0; nw = 0; rd = '0; er = '0;
        @(negedge clk);
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (rsp_valid) begin
                if (nv == 0) begin
                    lat = k; rd = rsp_rdata; er = rsp_err;
                end
                nv++;
            end
            if (dmem_wr_en) nw++;
        end
        check_eq({tag, "_lat"},    32'(lat), 32'(exp_lat));
        check_eq({tag, "_pulses"}, 32'(nv),  32'd1);
        check_eq({tag, "_wr_en"},  32'(nw),  32'(exp_wr));
        check_eq({tag, "_rdata"},  rd,       exp_rdata);
        check_eq({tag, "_err"},    {30'd0, er}, {30'd0, exp_err});
    endtask

    initial begin
        int nbad;
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_wr_en",     {31'd0, dmem_wr_en}, 32'd0);
        check_eq("rst_addr",      {22'd0, dmem_addr}, 32'd0);
        check_eq("rst_wr_data",   dmem_wr_data, 32'd0);
        check_eq("rst_rdata",     rsp_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);

        // Word store then load
        do_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 2'b00, 1);
        do_req("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 2'b00, 0);

        // Sub-word loads
        do_req("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 2, 32'hFFFFFFDE, 2'b00, 0);
        do_req("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h000000DE, 2'b00, 0);
        do_req("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 2, 32'hFFFFBEEF, 2'b00, 0);
        do_req("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 2, 32'h0000DEAD, 2'b00, 0);
        do_req("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 2, 32'hFFFFDEAD, 2'b00, 0);
        do_req("lb_10",  1'b0, 3'b000, 32'h10, 32'h0, 2, 32'hFFFFFFEF, 2'b00, 0);
        do_req("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 2, 32'h000000BE, 2'b00, 0);

        // Read-modify-write stores
        do_req("sb_11",  1'b1, 3'b000, 32'h11, 32'hFFFFFFAA, 3, 32'h0, 2'b00, 1);
        do_req("lw_sb",  1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADAAEF, 2'b00, 0);
        do_req("sh_12",  1'b1, 3'b001, 32'h12, 32'hABCD1234, 3, 32'h0, 2'b00, 1);
        do_req("lw_sh",  1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h1234AAEF, 2'b00, 0);
        do_req("sw_20",  1'b1, 3'b010, 32'h20, 32'h00000000, 1, 32'h0, 2'b00, 1);
        do_req("sb_20",  1'b1, 3'b000, 32'h20, 32'h1234565A, 3, 32'h0, 2'b00, 1);
        do_req("sb_23",  1'b1, 3'b000, 32'h23, 32'h00000080, 3, 32'h0, 2'b00, 1);
        do_req("lw_20",  1'b0, 3'b010, 32'h20, 32'h0, 2, 32'h8000005A, 2'b00, 0);
        do_req("lb_23",  1'b0, 3'b000, 32'h23, 32'h0, 2, 32'hFFFFFF80, 2'b00, 0);
        do_req("sh_20",  1'b1, 3'b001, 32'h20, 32'h00008001, 3, 32'h0, 2'b00, 1);
        do_req("lw_20b", 1'b0, 3'b010, 32'h20, 32'h0, 2, 32'h80008001, 2'b00, 0);

        // Error responses: no DMEM access, one-cycle latency
        do_req("e_lw_12",  1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 2'b01, 0);
        do_req("e_sh_11",  1'b1, 3'b001, 32'h11, 32'hFFFF, 1, 32'h0, 2'b01, 0);
        do_req("e_lh_13",  1'b0, 3'b001, 32'h13, 32'h0, 1, 32'h0, 2'b01, 0);
        do_req("e_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 2'b10, 0);
        do_req("e_f3_pri", 1'b0, 3'b111, 32'h13, 32'h0, 1, 32'h0, 2'b10, 0);
        do_req("e_sbu",    1'b1, 3'b100, 32'h10, 32'h77, 1, 32'h0, 2'b10, 0);
        do_req("lw_after_err", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h1234AAEF, 2'b00, 0);

        // Reset during SB's merge cycle abandons the store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h11; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_wr_en", {31'd0, dmem_wr_en}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("mid_rst_addr",  {22'd0, dmem_addr}, 32'd0);
        nbad = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (dmem_wr_en || rsp_valid) nbad++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (dmem_wr_en || rsp_valid) nbad++;
        end
        check_eq("mid_rst_quiet", 32'(nbad), 32'd0);
        do_req("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h1234AAEF, 2'b00, 0);

        // Upper address bits
        do_req("sw_00", 1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 1, 32'h0, 2'b00, 1);
`ifdef LSU_RANGE_CHECK_EN
        do_req("lw_400", 1'b0, 3'b010, 32'h400, 32'h0, 1, 32'h0, 2'b11, 0);
`else
        do_req("lw_400", 1'b0, 3'b010, 32'h400, 32'h0, 2, 32'hCAFEF00D, 2'b00, 0);
`endif
        do_req("e_403_f3", 1'b0, 3'b110, 32'h403, 32'h0, 1, 32'h0, 2'b10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit sitting directly upstream of the byte-addressed, little-endian data memory (DMEM) in the RISC-V core's memory stage.
- Accepts one load or store per request from the execute stage.
- Issues word-aligned DMEM accesses and extracts/sign-extends load data per funct3.
- Implements SB/SH as read-modify-write, because DMEM writes only full 32-bit words.
- Returns a single-cycle response pulse carrying load data or an error code.

Parameters:
DMEM_ADDR_WIDTH, 10, DMEM byte-address width; DMEM depth = 2^DMEM_ADDR_WIDTH bytes
REG_WIDTH, 32, register/data width; only 32 is supported

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; handshake = req_valid & req_ready at rising edge
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  REG_WIDTH  byte address
req_wdata  input  REG_WIDTH  store data (low byte/half used for SB/SH)
rsp_valid  output  1  one-cycle completion pulse; no backpressure, consumer must take it
rsp_rdata  output  REG_WIDTH  extended load data; 0 for stores and errors
rsp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 range fault
dmem_wr_en  output  1  DMEM write enable (registered)
dmem_addr  output  DMEM_ADDR_WIDTH  DMEM byte address, always [1:0]=00 (registered)
dmem_wr_data  output  REG_WIDTH  DMEM write word (registered)
dmem_data_out  input  REG_WIDTH  DMEM read word, valid the cycle after DMEM samples dmem_addr

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1 after release; rsp_valid=0, rsp_rdata=0, rsp_err=00, dmem_wr_en=0, dmem_addr=0, dmem_wr_data=0. Reset mid-operation abandons the request; a pending sub-word store is not written and no response is produced.
- DMEM model: writes at the rising edge when wr_en=1. Reads are registered, so a read sampled at edge E returns data after E. A same-edge read returns the pre-write contents.
- States: IDLE, RD (DMEM sampling address), MRG (read data valid), WR (write word presented).
- Request accepted at edge N, with A = req_addr & ~3 truncated to DMEM_ADDR_WIDTH and lane = req_addr[1:0]:
  - Error check first: illegal funct3 (011, 110, 111, or store with 100/101) -> 10. Half access with addr[0]=1 -> 01. Word access with addr[1:0]!=0 -> 01. Priority: 10 > 01 > 11. On error, no DMEM access: rsp_valid=1 after N+1 with rsp_err set, rsp_rdata=0, state stays IDLE.
  - Load: edge N dmem_addr<=A, ->RD. Edge N+1 ->MRG. Edge N+2: rsp_rdata<=extract(dmem_data_out, lane, funct3), rsp_valid<=1, ->IDLE. Response pulse in cycle after N+2.
  - Extract: B/H sign-extend, BU/HU zero-extend. Byte lane = bits [8*lane+7:8*lane]; half = bits [16*lane[1]+15:16*lane[1]]. W = whole word.
  - SW: edge N dmem_addr<=A, dmem_wr_data<=req_wdata, dmem_wr_en<=1, ->WR. Edge N+1: DMEM writes, dmem_wr_en<=0, rsp_valid<=1, ->IDLE.
  - SB/SH: edge N dmem_addr<=A, ->RD. Edge N+1 ->MRG. Edge N+2: dmem_wr_data<=dmem_data_out with target lane(s) replaced from req_wdata (captured at N), dmem_wr_en<=1, ->WR. Edge N+3: write, rsp_valid<=1, ->IDLE.
- req_ready = (state==IDLE) and is combinational from state. The next request is accepted at the earliest on the edge after the response is registered; back-to-back requests have no overlap.
- req_* must be sampled only at acceptance; changes afterward are ignored.
- rsp_valid is high for exactly one cycle per accepted request.
- dmem_wr_en is never high outside WR.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: req_addr[REG_WIDTH-1:DMEM_ADDR_WIDTH] != 0 on an otherwise legal request -> rsp_err=11, no DMEM access, error response after N+1.
- Undefined: upper address bits are ignored (address wraps modulo DMEM size); rsp_err never equals 11.

Test Plan:
1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> dmem_wr_en for exactly one cycle; LW rsp_rdata=0xDEADBEEF, rsp_err=00, rsp_valid exactly 2 cycles after load acceptance edge.
2. LB 0x13 and LBU 0x13 on word 0xDEADBEEF -> 0xFFFFFFDE and 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
3. SB 0x11 data 0x000000AA over 0xDEADBEEF, then LW 0x10 -> 0xDEADAAEF; SH 0x12 data 0x1234 -> 0x1234AAEF; each store response 3 cycles after acceptance.
4. LW 0x12, SH 0x11, funct3=011 -> rsp_err 01, 01, 10; no dmem_wr_en pulse; memory unchanged; response 1 cycle after acceptance.
5. Assert reset_n low during SB's MRG state -> outputs 0 immediately, no write occurs, no rsp_valid; subsequent LW returns the old word.
6. With LSU_RANGE_CHECK_EN, LW 0x400 (DMEM_ADDR_WIDTH=10) -> rsp_err 11. Without the macro -> data read from 0x000.
